vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Arbiter for the single-port 640x480 frame-buffer RAM, shared between the VGA scan-out path and the processor/image-processing write port. The VGA requester, driven by the pixel address from the VGA memory map, has strict priority. The processor's single outstanding request is parked in a one-deep holding register and issued in the first cycle the VGA path does not need the RAM. A starvation monitor flags processor requests that wait too long behind scan-out.

## Interface
Parameters:
- ADDR_W, 19, frame-buffer word address width
- DATA_W, 8, pixel width
- FB_SIZE, 307200, number of valid addresses (640*480)
- STARVE_LIMIT, 800, wait cycles before the starve flag sets (16-bit counter)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA needs a pixel read this cycle
- vga_addr  in  ADDR_W  VGA read address
- vga_data  out  DATA_W  registered pixel data
- vga_valid  out  1  vga_data valid this cycle
- cpu_req  in  1  processor request strobe
- cpu_ready  out  1  holding register empty; request accepted when cpu_req & cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  registered read data
- cpu_rvalid  out  1  cpu_rdata valid (reads only)
- mem_addr  out  ADDR_W  RAM address (combinational from grant)
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after address
- starve_clr  in  1  clears the starve flag
- starve  out  1  sticky starvation flag

## Operation
- Holding FSM:
  - EMPTY: cpu_ready=1. On cpu_req, latch we/addr/wdata and go to HELD.
  - HELD: cpu_ready=0. Leave for EMPTY in the cycle the request is issued.
  - Acceptance and issue never occur in the same cycle. Maximum CPU throughput is one request per 2 cycles.
- Grant, evaluated every cycle:
  - vga_req=1: mem_addr=vga_addr, mem_we=0. Owner tag is VGA.
  - Otherwise, if HELD: mem_addr=held addr, mem_we=held we & in-range, mem_wdata=held wdata. Owner tag is CPU_RD for reads and NONE for writes.
  - Otherwise: mem_we=0, mem_addr=0, owner tag NONE.
- Range check: a held addr >= FB_SIZE is still issued but has mem_we forced to 0. If it is a read, it returns cpu_rdata=0 with cpu_rvalid.
- Response pipe:
  - The owner tag is registered at issue. One cycle later mem_rdata is captured into vga_data or cpu_rdata, according to the tag.
  - The matching valid is asserted for exactly one cycle.
- Starvation:
  - A 16-bit wait counter clears on entry to HELD and increments each HELD cycle in which vga_req=1. It saturates at its maximum.
  - When the counter reaches STARVE_LIMIT, starve sets and stays set until starve_clr=1 or reset.
  - If starve_clr and the set condition coincide, the set wins.
- The VGA path is never stalled, so no underrun is possible.

## Timing
- Reset (rst=0, asynchronous):
  - Outputs: vga_data=0, vga_valid=0, cpu_rdata=0, cpu_rvalid=0, starve=0, cpu_ready=1, mem_we=0, mem_addr=0.
  - Internal state: FSM in EMPTY, owner tags NONE, wait counter 0.
- Reset mid-operation: the held request is discarded and the write is not performed. In-flight responses are cancelled and produce no valid pulse.
- Latency (request in cycle t):
  - VGA: vga_req at t gives vga_valid and vga_data at t+2.
  - CPU, uncontended: accepted at t, issued at t+1. A read gives cpu_rvalid at t+3. A write reaches the RAM at the t+1 edge. cpu_ready returns high at t+2.
  - CPU, contended: issue slips one cycle per consecutive vga_req=1 cycle.
- Data hazard: a CPU write issued at t followed by a VGA read of the same address at t+1 returns the new data.

## Test plan
- Reset check: hold rst=0 and drive random inputs -> all outputs at the reset values above, cpu_ready=1. Release reset -> first vga_req produces vga_valid exactly 2 cycles later.
- Idle CPU write then read:
  - Accept write addr=100, data=0x5A at t with vga_req=0 -> mem_we=1, mem_addr=100 at t+1; cpu_ready=1 at t+2.
  - Then a read of addr 100 -> cpu_rdata=0x5A exactly 3 cycles after acceptance.
- Contention:
  - Accept a CPU read while vga_req=1 for 10 cycles -> no CPU issue during those cycles, vga_valid every cycle.
  - CPU issue in the first cycle vga_req drops.
  - Response streams are never cross-routed.
- Out of range:
  - Write to addr 307200 -> mem_we stays 0.
  - Read of addr 307200 -> cpu_rvalid with cpu_rdata=0.
- Starvation: STARVE_LIMIT=8, CPU request held under 8 continuous vga_req=1 cycles -> starve=1 on the 8th cycle and stays set after service; pulse starve_clr -> starve=0 next cycle.
- Reset mid-operation: assert rst while HELD with a pending write to addr 5 -> RAM addr 5 unchanged, no cpu_rvalid or vga_valid after release.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus bundle: VGA read port, processor port and RAM port.
//
// Processor handshake: a request is accepted on a rising edge where cpu_req
// and cpu_ready are both 1; cpu_we/cpu_addr/cpu_wdata are sampled on that
// edge only. cpu_ready depends only on registered state, never on cpu_req.
// Responses carry no back-pressure: vga_valid and cpu_rvalid are one-cycle
// pulses that the consumer must take when they are high.
//
// slave  = arbiter side (takes VGA/processor requests, drives the RAM port).
// master = environment side (requesters and the RAM model).
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;

    logic              cpu_req;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Holding-register FSM state for observation (1 = request held)
    logic              fsm_state;

    modport slave (
        input  vga_req, vga_addr,
        output vga_data, vga_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_rvalid,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output fsm_state
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_data, vga_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  fsm_state
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter. VGA scan-out reads have strict priority;
// one processor request is parked in a holding register and issued in the
// first cycle VGA leaves the RAM idle. A sticky flag reports processor
// requests that waited STARVE_LIMIT contended cycles.
module vga_fb_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int FB_SIZE      = 307200,
    parameter int STARVE_LIMIT = 800
) (
    input  logic            clk,
    input  logic            rst,
    vga_fb_arbiter_if.slave bus,
    input  logic            starve_clr,
    output logic            starve
);
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_SIZE);
    localparam logic [15:0]     LIMIT_W  = 16'(STARVE_LIMIT);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    // Who owns the RAM read data returning next cycle
    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_VGA     = 2'd1,
        TAG_CPU_RD  = 2'd2,
        TAG_CPU_OOR = 2'd3
    } tag_t;

    state_t            state_q, state_d;
    logic              held_we_q, held_we_d;
    logic [ADDR_W-1:0] held_addr_q, held_addr_d;
    logic [DATA_W-1:0] held_wdata_q, held_wdata_d;
    tag_t              tag_q, tag_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic              starve_q, starve_d;

    logic              held_in_range;
    logic              starve_set;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_wdata_c;

    assign held_in_range = ({1'b0, held_addr_q} < FB_LIMIT);

    // RAM grant: VGA first, then the held request; RAM idle while in reset
    always_comb begin
        mem_addr_c  = '0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        tag_d       = TAG_NONE;
        if (!rst) begin
            tag_d = TAG_NONE;
        end else if (bus.vga_req) begin
            mem_addr_c = bus.vga_addr;
            tag_d      = TAG_VGA;
        end else if (state_q == S_HELD) begin
            mem_addr_c  = held_addr_q;
            mem_we_c    = held_we_q & held_in_range;
            mem_wdata_c = held_wdata_q;
            if (!held_we_q) begin
                tag_d = held_in_range ? TAG_CPU_RD : TAG_CPU_OOR;
            end
        end
    end

    // Next state: holding FSM, wait counter, starve flag, response capture
    always_comb begin
        state_d      = state_q;
        held_we_d    = held_we_q;
        held_addr_d  = held_addr_q;
        held_wdata_d = held_wdata_q;
        wait_cnt_d   = wait_cnt_q;
        starve_set   = 1'b0;

        vga_valid_d  = (tag_q == TAG_VGA);
        vga_data_d   = (tag_q == TAG_VGA) ? bus.mem_rdata : vga_data_q;
        cpu_rvalid_d = (tag_q == TAG_CPU_RD) || (tag_q == TAG_CPU_OOR);
        case (tag_q)
            TAG_CPU_RD:  cpu_rdata_d = bus.mem_rdata;
            TAG_CPU_OOR: cpu_rdata_d = '0;
            default:     cpu_rdata_d = cpu_rdata_q;
        endcase

        case (state_q)
            S_EMPTY: begin
                if (bus.cpu_req) begin
                    state_d      = S_HELD;
                    held_we_d    = bus.cpu_we;
                    held_addr_d  = bus.cpu_addr;
                    held_wdata_d = bus.cpu_wdata;
                    wait_cnt_d   = '0;
                end
            end
            default: begin
                if (bus.vga_req) begin
                    // Blocked by scan-out: count the wait, saturating
                    if (wait_cnt_q != 16'hFFFF) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                        starve_set = ((wait_cnt_q + 16'd1) == LIMIT_W);
                    end
                end else begin
                    // Issued this cycle by the grant logic
                    state_d = S_EMPTY;
                end
            end
        endcase

        if (starve_set) begin
            starve_d = 1'b1;
        end else if (starve_clr) begin
            starve_d = 1'b0;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset discards the held request and in-flight responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EMPTY;
            held_we_q    <= 1'b0;
            held_addr_q  <= '0;
            held_wdata_q <= '0;
            tag_q        <= TAG_NONE;
            vga_data_q   <= '0;
            vga_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            wait_cnt_q   <= '0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_we_q    <= held_we_d;
            held_addr_q  <= held_addr_d;
            held_wdata_q <= held_wdata_d;
            tag_q        <= tag_d;
            vga_data_q   <= vga_data_d;
            vga_valid_q  <= vga_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.vga_data   = vga_data_q;
    assign bus.vga_valid  = vga_valid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_ready  = (state_q == S_EMPTY);
    assign bus.fsm_state  = (state_q == S_HELD);
    assign starve         = starve_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model on the mem port, a transaction-level
// reference (pending request, reference memory, expected response queues)
// and directed plus randomized stimulus.
module tb_vga_fb_arbiter;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 8;
    localparam int FB_SIZE = 307200;
    localparam int LIMIT   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic starve_clr = 1'b0;
    logic starve;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(FB_SIZE), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .starve_clr(starve_clr), .starve(starve)
    );

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return DATA_W'(i * 7 + 3);
    endfunction

    function automatic bit in_fb(input logic [ADDR_W-1:0] a);
        return int'(a) < FB_SIZE;
    endfunction

    // RAM model: read data valid one cycle after the address, out-of-range reads return junk
    logic [DATA_W-1:0] ram [0:FB_SIZE-1];
    initial begin
        logic [DATA_W-1:0] rd;
        for (int i = 0; i < FB_SIZE; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            rd = in_fb(bus.mem_addr) ? ram[bus.mem_addr] : 8'hEE;
            if (bus.mem_we && in_fb(bus.mem_addr)) ram[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata <= rd;
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:FB_SIZE-1];
    bit                m_held;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    int                m_wait;
    bit                m_starve;
    int                vga_due_q[$];
    logic [DATA_W-1:0] vga_exp_q[$];
    int                cpu_due_q[$];
    logic [DATA_W-1:0] cpu_exp_q[$];
    logic [DATA_W-1:0] last_cpu_rdata;
    bit                obs_starve;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_wait = 0;
        m_starve = 1'b0;
        vga_due_q.delete();
        vga_exp_q.delete();
        cpu_due_q.delete();
        cpu_exp_q.delete();
    endtask

    task automatic check_reset_outs();
        check("rst_vga_data",   32'(bus.vga_data),   32'd0);
        check("rst_vga_valid",  32'(bus.vga_valid),  32'd0);
        check("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
        check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_starve",     32'(starve),         32'd0);
        check("rst_cpu_ready",  32'(bus.cpu_ready),  32'd1);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    endtask

    task automatic drive_random();
        bus.vga_req   = 1'($urandom_range(0, 1));
        bus.vga_addr  = ADDR_W'($urandom_range(0, 31));
        bus.cpu_req   = 1'($urandom_range(0, 1));
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = ADDR_W'($urandom_range(0, 31));
        bus.cpu_wdata = DATA_W'($urandom_range(0, 255));
        starve_clr    = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_idle();
        bus.vga_req = 1'b0; bus.vga_addr = '0; bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; starve_clr = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input bit vr, input logic [ADDR_W-1:0] va, input bit cr, input bit cw,
                        input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd, input bit clr);
        bit                exp_we;
        logic [ADDR_W-1:0] exp_addr;
        bit                due;
        bit                h;
        bit                set;
        @(negedge clk);
        bus.vga_req = vr; bus.vga_addr = va; bus.cpu_req = cr; bus.cpu_we = cw;
        bus.cpu_addr = ca; bus.cpu_wdata = cd; starve_clr = clr;
        #1;
        exp_we = 1'b0;
        exp_addr = '0;
        if (vr) begin
            exp_addr = va;
        end else if (m_held) begin
            exp_addr = m_addr;
            exp_we = m_we && in_fb(m_addr);
        end
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        check("mem_we", 32'(bus.mem_we), 32'(exp_we));
        if (exp_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        check("cpu_ready", 32'(bus.cpu_ready), 32'(!m_held));
        check("fsm_state", 32'(bus.fsm_state), 32'(m_held));
        check("starve", 32'(starve), 32'(m_starve));
        obs_starve = starve;

        due = (vga_due_q.size() > 0) && (vga_due_q[0] == cyc);
        check("vga_valid", 32'(bus.vga_valid), 32'(due));
        if (due) begin
            check("vga_data", 32'(bus.vga_data), 32'(vga_exp_q[0]));
            void'(vga_due_q.pop_front());
            void'(vga_exp_q.pop_front());
        end
        due = (cpu_due_q.size() > 0) && (cpu_due_q[0] == cyc);
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(due));
        if (due) begin
            check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp_q[0]));
            last_cpu_rdata = bus.cpu_rdata;
            void'(cpu_due_q.pop_front());
            void'(cpu_exp_q.pop_front());
        end

        h = m_held;
        set = 1'b0;
        if (vr) begin
            vga_due_q.push_back(cyc + 2);
            vga_exp_q.push_back(ref_mem[va]);
        end else if (h) begin
            if (m_we) begin
                if (in_fb(m_addr)) ref_mem[m_addr] = m_wdata;
            end else begin
                cpu_due_q.push_back(cyc + 2);
                cpu_exp_q.push_back(in_fb(m_addr) ? ref_mem[m_addr] : '0);
            end
            m_held = 1'b0;
        end
        if (h && vr && m_wait < 65535) begin
            m_wait++;
            if (m_wait == LIMIT) set = 1'b1;
        end
        if (set) m_starve = 1'b1;
        else if (clr) m_starve = 1'b0;
        if (!h && cr) begin
            m_held = 1'b1; m_we = cw; m_addr = ca; m_wdata = cd; m_wait = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int pct;
        bit vr;
        bit cr;
        bit cw;
        bit clr;
        logic [ADDR_W-1:0] ca;

        for (int i = 0; i < FB_SIZE; i++) ref_mem[i] = init_val(i);
        model_reset();
        drive_idle();

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_reset_outs();
        end
        drive_idle();
        rst = 1'b1;

        // First VGA read after reset, then idle CPU write/read of addr 100
        step(1'b1, 19'd9, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);
        step(1'b0, '0, 1'b1, 1'b1, 19'd100, 8'h5A, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0, 19'd100, 8'h00, 1'b0);
        idle(4);
        check("rd100_data", 32'(last_cpu_rdata), 32'h5A);

        // Write then VGA read of the same address on the next cycle
        step(1'b0, '0, 1'b1, 1'b1, 19'd12, 8'h3C, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 19'd12, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);

        // Contention: CPU read accepted under 10 cycles of scan-out
        step(1'b1, 19'd0, 1'b1, 1'b0, 19'd30, 8'h00, 1'b0);
        for (int i = 1; i < 10; i++) step(1'b1, ADDR_W'(i), 1'b0, 1'b0, '0, '0, 1'b0);
        idle(4);

        // Out-of-range write and read
        step(1'b0, '0, 1'b1, 1'b1, 19'(FB_SIZE), 8'h77, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0, 19'(FB_SIZE), 8'h00, 1'b0);
        idle(4);
        check("oor_rdata", 32'(last_cpu_rdata), 32'h0);

        // Starvation: 8 contended cycles set the flag, clear pulse drops it
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0, 19'd20, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, ADDR_W'(i), 1'b0, 1'b0, '0, '0, 1'b0);
        check("starve_before", 32'(obs_starve), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("starve_set", 32'(obs_starve), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        check("starve_sticky", 32'(obs_starve), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("starve_cleared", 32'(obs_starve), 32'd0);
        idle(2);

        // Reset while a write to addr 5 is held and a VGA read is in flight
        step(1'b1, 19'd3, 1'b1, 1'b1, 19'd5, 8'hC3, 1'b0);
        step(1'b1, 19'd4, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive_random();
        #1;
        check_reset_outs();
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outs();
        drive_idle();
        rst = 1'b1;
        idle(5);
        check("ram5_kept", 32'(ram[5]), 32'(init_val(5)));

        // Randomized traffic in blocks of varying scan-out load
        for (int blk = 0; blk < 12; blk++) begin
            pct = int'($urandom_range(0, 95));
            for (int k = 0; k < 100; k++) begin
                vr  = ($urandom_range(0, 99) < pct);
                cr  = ($urandom_range(0, 1) == 1);
                cw  = ($urandom_range(0, 1) == 1);
                clr = ($urandom_range(0, 29) == 0);
                ca  = ($urandom_range(0, 19) == 0) ? ADDR_W'(FB_SIZE + int'($urandom_range(0, 3)))
                                                   : ADDR_W'($urandom_range(0, 31));
                step(vr, ADDR_W'($urandom_range(0, 31)), cr, cw, ca,
                     DATA_W'($urandom_range(0, 255)), clr);
            end
        end
        idle(4);
        check("vga_drained", 32'(vga_due_q.size()), 32'd0);
        check("cpu_drained", 32'(cpu_due_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
